// File: rtl/dmem_chk_pkg.sv
// Shared types and defaults for the data-memory store checker.
package dmem_chk_pkg;

   typedef enum logic [1:0] {
      ST_ARMED   = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_t;

   localparam logic [31:0] DEF_PASS_ADDR    = 32'd100;
   localparam logic [31:0] DEF_PASS_DATA    = 32'd25;
   localparam logic [31:0] DEF_ALLOWED_ADDR = 32'd96;
   localparam int unsigned LOG_W            = 64;

   // Log entry layout: address in the upper word, data in the lower word.
   function automatic logic [LOG_W-1:0] pack_entry(input logic [31:0] adr,
                                                   input logic [31:0] dat);
      return {adr, dat};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy counter.
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int unsigned    AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
   localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CNT_FULL);
   // A pop frees the slot for a push on the same edge when full.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign rdata     = empty ? '0 : r_mem[r_rptr];

   // Pointer and occupancy update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array, written only on an effective push.
   always_ff @(posedge clk) begin
      if (rst_n && w_do_push) r_mem[r_wptr] <= wdata;
   end

endmodule

// File: rtl/dmem_write_checker.sv
// Watches core stores and reaches a pass/fail/timeout verdict; logs accepted stores.
module dmem_write_checker
   import dmem_chk_pkg::*;
#(
   parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
   parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
   parameter logic [31:0] ALLOWED_ADDR   = DEF_ALLOWED_ADDR,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned LOG_DEPTH      = 8,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MemWrite,
   input  logic [31:0]      DataAdr,
   input  logic [31:0]      WriteData,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [CNT_W-1:0] store_count,
   input  logic             log_rd_en,
   output logic [63:0]      log_rd_data,
   output logic             log_empty,
   output logic             log_full,
   output logic             log_overflow
);

   localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_d;
   logic [CNT_W-1:0] r_cyc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pass;
   logic             r_fail;
   logic             r_timeout;
   logic             r_done;
   logic             r_ovf;
   logic             w_armed;
   logic             w_accept;

   assign w_armed  = (r_state == ST_ARMED);
   assign w_accept = MemWrite && w_armed;

   // Next-state: a store verdict overrides a timeout landing on the same edge.
   always_comb begin
      w_state_d = r_state;
      if (w_armed) begin
         if (r_cyc == CYC_LAST) w_state_d = ST_TIMEOUT;
         if (MemWrite) begin
            if (DataAdr == PASS_ADDR) begin
               w_state_d = (WriteData == PASS_DATA) ? ST_PASS : ST_FAIL;
            end else if (DataAdr != ALLOWED_ADDR) begin
               w_state_d = ST_FAIL;
            end
         end
      end
   end

   // State register with registered verdict flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_ARMED;
         r_pass    <= 1'b0;
         r_fail    <= 1'b0;
         r_timeout <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_pass    <= (w_state_d == ST_PASS);
         r_fail    <= (w_state_d == ST_FAIL);
         r_timeout <= (w_state_d == ST_TIMEOUT);
         r_done    <= (w_state_d != ST_ARMED);
      end
   end

   // Saturating cycle and store counters, plus sticky log overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cyc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_armed && (r_cyc != CNT_MAX)) r_cyc <= r_cyc + CNT_ONE;
         if (w_accept && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_ONE;
         // Full log only accepts a push when the same edge pops.
         if (w_accept && log_full && !log_rd_en) r_ovf <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (LOG_W),
      .DEPTH (LOG_DEPTH)
   ) u_log (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_accept),
      .pop   (log_rd_en),
      .wdata (pack_entry(DataAdr, WriteData)),
      .rdata (log_rd_data),
      .empty (log_empty),
      .full  (log_full)
   );

   assign done         = r_done;
   assign pass         = r_pass;
   assign fail         = r_fail;
   assign timeout      = r_timeout;
   assign store_count  = r_cnt;
   assign log_overflow = r_ovf;

endmodule

// File: tb/tb_dmem_write_checker.sv
// Scoreboard bench for dmem_write_checker against a queue-based behavioural model.
module tb_dmem_write_checker;

   localparam int unsigned TO    = 20;
   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;
   logic [15:0] store_count;
   logic        log_rd_en;
   logic [63:0] log_rd_data;
   logic        log_empty;
   logic        log_full;
   logic        log_overflow;

   always #5 clk = ~clk;

   dmem_write_checker #(
      .TIMEOUT_CYCLES (TO),
      .LOG_DEPTH      (DEPTH),
      .CNT_W          (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .MemWrite     (MemWrite),
      .DataAdr      (DataAdr),
      .WriteData    (WriteData),
      .done         (done),
      .pass         (pass),
      .fail         (fail),
      .timeout      (timeout),
      .store_count  (store_count),
      .log_rd_en    (log_rd_en),
      .log_rd_data  (log_rd_data),
      .log_empty    (log_empty),
      .log_full     (log_full),
      .log_overflow (log_overflow)
   );

   typedef struct {
      logic        done;
      logic        pass;
      logic        fail;
      logic        tmo;
      logic [15:0] cnt;
      logic [63:0] rd;
      logic        empty;
      logic        full;
      logic        ovf;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Model: verdict 0=running 1=pass 2=fail 3=timeout.
   int          m_verdict;
   int          m_cycles;
   int          m_count;
   bit          m_ovf;
   logic [63:0] m_log[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input bit we, input logic [31:0] a,
                             input logic [31:0] d, input bit rd);
      bit popped;
      bit was_full;
      bit do_push;
      int v;
      if (!rst) begin
         m_verdict = 0;
         m_cycles  = 0;
         m_count   = 0;
         m_ovf     = 0;
         m_log.delete();
         return;
      end
      popped   = rd && (m_log.size() > 0);
      was_full = (m_log.size() == DEPTH);
      do_push  = 0;
      if (m_verdict == 0) begin
         v = 0;
         if (we) begin
            if (m_count < 65535) m_count++;
            if (a == 100) v = (d == 25) ? 1 : 2;
            else if (a != 96) v = 2;
            if (was_full && !popped) m_ovf = 1;
            else do_push = 1;
         end
         if (v == 0 && m_cycles == TO - 1) v = 3;
         if (m_cycles < 65535) m_cycles++;
         m_verdict = v;
      end
      if (popped) void'(m_log.pop_front());
      if (do_push) m_log.push_back({a, d});
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.done  = (m_verdict != 0);
      e.pass  = (m_verdict == 1);
      e.fail  = (m_verdict == 2);
      e.tmo   = (m_verdict == 3);
      e.cnt   = m_count[15:0];
      e.rd    = (m_log.size() > 0) ? m_log[0] : 64'd0;
      e.empty = (m_log.size() == 0);
      e.full  = (m_log.size() == DEPTH);
      e.ovf   = m_ovf;
      return e;
   endfunction

   // One clock edge of stimulus; expectation is queued once the edge has happened.
   task automatic step(input bit rst, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input bit rd);
      exp_t e;
      rst_n     = rst;
      MemWrite  = we;
      DataAdr   = a;
      WriteData = d;
      log_rd_en = rd;
      model_edge(rst, we, a, d, rd);
      e = model_out();
      @(posedge clk);
      q.push_back(e);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, $urandom, $urandom, 0);
   endtask

   task automatic rst_edge();
      step(0, 0, 32'd0, 32'd0, 0);
   endtask

   // Monitor: compare DUT outputs against the oldest pending expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("done",         {63'd0, done},         {63'd0, e.done});
         chk("pass",         {63'd0, pass},         {63'd0, e.pass});
         chk("fail",         {63'd0, fail},         {63'd0, e.fail});
         chk("timeout",      {63'd0, timeout},      {63'd0, e.tmo});
         chk("store_count",  {48'd0, store_count},  {48'd0, e.cnt});
         chk("log_rd_data",  log_rd_data,           e.rd);
         chk("log_empty",    {63'd0, log_empty},    {63'd0, e.empty});
         chk("log_full",     {63'd0, log_full},     {63'd0, e.full});
         chk("log_overflow", {63'd0, log_overflow}, {63'd0, e.ovf});
      end
   end

   initial begin
      int unsigned r;
      int          n;
      bit          we;
      logic [31:0] a;
      logic [31:0] d;
      rst_n = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; log_rd_en = 1'b0;

      // Pass sequence, then drain the log (last pop hits empty).
      rst_edge();
      step(1, 1, 32'd96, 32'd7, 0);
      step(1, 1, 32'd96, 32'd10, 0);
      step(1, 1, 32'd100, 32'd25, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 32'd0, 32'd0, 1);

      // Wrong data at pass address, later pass store ignored.
      rst_edge();
      step(1, 1, 32'd100, 32'd24, 0);
      step(1, 1, 32'd100, 32'd25, 0);
      idle(1);

      // Store to an unexpected address.
      rst_edge();
      step(1, 1, 32'd104, 32'd25, 0);
      idle(1);

      // Timeout, then a pass store landing on the timeout edge.
      rst_edge();
      idle(TO + 2);
      rst_edge();
      idle(TO - 1);
      step(1, 1, 32'd100, 32'd25, 0);
      idle(2);

      // Fill, overflow, pop-and-push while full, drain.
      rst_edge();
      for (int i = 0; i < 10; i++) step(1, 1, 32'd96, 32'(i + 1), 0);
      step(1, 1, 32'd96, 32'd99, 1);
      for (int i = 0; i < 9; i++) step(1, 0, 32'd0, 32'd0, 1);

      // Reset out of PASS with a non-empty log.
      rst_edge();
      step(1, 1, 32'd96, 32'd1, 0);
      step(1, 1, 32'd100, 32'd25, 0);
      rst_edge();
      idle(1);
      step(1, 1, 32'd100, 32'd25, 0);
      idle(1);

      // Randomised runs.
      for (int it = 0; it < 30; it++) begin
         rst_edge();
         n = 15 + int'($urandom_range(25, 0));
         for (int k = 0; k < n; k++) begin
            we = ($urandom_range(2, 0) != 0);
            r  = $urandom_range(15, 0);
            if (r < 12)       a = 32'd96;
            else if (r < 14)  a = 32'd100;
            else if (r == 14) a = 32'd104;
            else              a = $urandom;
            d = ($urandom_range(1, 0) == 1) ? 32'd25 : $urandom;
            step(($urandom_range(39, 0) != 0), we, a, d, ($urandom_range(2, 0) == 0));
         end
      end

      MemWrite  = 1'b0;
      log_rd_en = 1'b0;
      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
